// File: rtl/spike_aer_encoder_if.sv
// rtl/spike_aer_encoder_if.sv - event stream handshake between the AER encoder and its consumer
//
// Signals:
//   ev_valid  encoder -> consumer  FIFO head holds a valid event
//   ev_data   encoder -> consumer  event word, EV_W bits
//   ev_ready  consumer -> encoder  consumer accepts ev_data this cycle
// Modports: master (encoder side), slave (consumer side).
interface spike_aer_encoder_if #(
    parameter int EV_W = 2
);
    logic            ev_valid;
    logic            ev_ready;
    logic [EV_W-1:0] ev_data;

    modport master (
        output ev_valid,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        output ev_ready
    );
endinterface

// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - encodes time-multiplexed LIF spikes into buffered address-event words
//
// Samples the LIF core spike output one neuron slot per spike_vld strobe, turns
// each spike into an event word and buffers it in a first-word-fall-through FIFO
// drained over a valid/ready handshake. Events arriving while the FIFO is full
// are dropped and counted.
//
// Optional feature macro: SPIKE_TIMESTAMP_EN
//   defined   : ev_data = {timestep, idx}, EV_W = TS_W + IDX_W
//   undefined : ev_data = idx,             EV_W = IDX_W, no timestep counter
//
// Ports:
//   clk         clock
//   rst_n       synchronous reset, active-low
//   spike_vld   strobe: spike_in is valid for the current slot
//   spike_in    spike from the LIF core
//   ovf_clr     clear overflow flag and drop counter
//   ev          event stream (master modport): ev_valid, ev_data, ev_ready
//   fifo_count  occupied FIFO entries
//   slot        neuron index the next spike_vld is attributed to
//   overflow    sticky: at least one event dropped
//   drop_cnt    dropped events, saturating at 255
module spike_aer_encoder #(
    parameter int N_NEURONS  = 4,
    parameter int IDX_W      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spike_vld,
    input  logic                          spike_in,
    input  logic                          ovf_clr,
    spike_aer_encoder_if.master           ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [IDX_W-1:0]              slot,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);
`ifdef SPIKE_TIMESTAMP_EN
    localparam int TS_BITS = TS_W;
`else
    // The timestamp field collapses to nothing when the feature is off.
    localparam int TS_BITS = TS_W * 0;
`endif
    localparam int EV_W = TS_BITS + IDX_W;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_NEURONS - 1);
    localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    logic [EV_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [AW:0]     cnt_after_pop;
    logic [AW:0]     count_next;
    logic [EV_W-1:0] ev_word;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            drop;
    logic            slot_wrap;

`ifdef SPIKE_TIMESTAMP_EN
    logic [TS_W-1:0] timestep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timestep <= '0;
        end else if (spike_vld && slot_wrap) begin
            timestep <= timestep + TS_W'(1);
        end
    end

    assign ev_word = {timestep, slot};
`else
    assign ev_word = slot;
`endif

    always_comb begin
        push          = spike_vld & spike_in;
        full          = (fifo_count == DEPTH_C);
        // ev_valid always mirrors a non-empty FIFO, so ready on an empty FIFO is ignored.
        pop           = ev.ev_valid & ev.ev_ready;
        // A pop in the same cycle frees the entry a push into a full FIFO needs.
        accept        = push & (~full | pop);
        drop          = push & full & ~pop;
        slot_wrap     = (slot == LAST_SLOT);
        cnt_after_pop = fifo_count - (AW + 1)'(pop);
        count_next    = cnt_after_pop + (AW + 1)'(accept);
        rd_next       = rd_ptr + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[wr_ptr] <= ev_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_data  <= '0;
            slot        <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (spike_vld) begin
                slot <= slot_wrap ? '0 : slot + IDX_W'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr      <= rd_next;
            fifo_count  <= count_next;
            ev.ev_valid <= (count_next != '0);
            // Registered head: when the FIFO is empty after the pop, the incoming
            // word bypasses memory so it is visible one cycle after the strobe.
            if (count_next != '0) begin
                ev.ev_data <= (cnt_after_pop == '0) ? ev_word : mem[rd_next];
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= ovf_clr ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb/tb_spike_aer_encoder.sv - self-checking bench for spike_aer_encoder
module tb_spike_aer_encoder;
    localparam int N_NEURONS  = 4;
    localparam int IDX_W      = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int TS_W       = 8;
`ifdef SPIKE_TIMESTAMP_EN
    localparam int EV_W = TS_W + IDX_W;
`else
    localparam int EV_W = IDX_W;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spike_vld = 1'b0;
    logic       spike_in = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] fifo_count;
    logic [1:0] slot;
    logic       overflow;
    logic [7:0] drop_cnt;

    spike_aer_encoder_if #(.EV_W(EV_W)) bus ();

    spike_aer_encoder #(
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TS_W      (TS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike_vld (spike_vld),
        .spike_in  (spike_in),
        .ovf_clr   (ovf_clr),
        .ev        (bus),
        .fifo_count(fifo_count),
        .slot      (slot),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [EV_W-1:0] sb_q[$];
    int m_slot = 0;
    int m_ts   = 0;
    int m_ovf  = 0;
    int m_drop = 0;

    typedef struct {
        logic v, i, r, c;
        int   exp_valid;
        int   exp_count;
        int   exp_slot;
        int   exp_ovf;
        int   exp_drop;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [EV_W-1:0] mk_ev(input int ts, input int idx);
        logic [7:0] t;
        logic [1:0] x;
        t = 8'(ts);
        x = 2'(idx);
`ifdef SPIKE_TIMESTAMP_EN
        return {t, x};
`else
        if (t == 8'hFF) x = x;
        return x;
`endif
    endfunction

    // Check current outputs against the model, apply one cycle of stimulus,
    // then advance the model with the pre-edge state.
    task automatic cycle(input logic v, input logic i, input logic r, input logic c);
        bit dropped;
        spike_vld    = v;
        spike_in     = i;
        bus.ev_ready = r;
        ovf_clr      = c;
        chk("ev_valid", 32'(bus.ev_valid), 32'(sb_q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(sb_q.size()));
        chk("slot", 32'(slot), 32'(m_slot));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (sb_q.size() != 0) begin
            chk("ev_data", 32'(bus.ev_data), 32'(sb_q[0]));
            if (r) void'(sb_q.pop_front());
        end
        dropped = 1'b0;
        if (v && i) begin
            if (sb_q.size() < FIFO_DEPTH) sb_q.push_back(mk_ev(m_ts, m_slot));
            else dropped = 1'b1;
        end
        if (dropped) begin
            m_ovf  = 1;
            m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (c) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        if (v) begin
            if (m_slot == N_NEURONS - 1) begin
                m_slot = 0;
                m_ts   = (m_ts + 1) % 256;
            end else begin
                m_slot++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle with push and pop requests asserted to show they are ignored.
    task automatic do_reset(input logic r);
        rst_n        = 1'b0;
        spike_vld    = 1'b1;
        spike_in     = 1'b1;
        bus.ev_ready = r;
        ovf_clr      = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        spike_vld = 1'b0;
        spike_in  = 1'b0;
        sb_q.delete();
        m_slot = 0;
        m_ts   = 0;
        m_ovf  = 0;
        m_drop = 0;
        chk("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_ev_data", 32'(bus.ev_data), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_slot", 32'(slot), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        logic [EV_W-1:0] exp_ev;
        bus.ev_ready = 1'b0;

        //                v     i     r     c    valid cnt slot ovf drop
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 2, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 3, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 0, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 2, 0, 0};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 0, 0};

        do_reset(1'b0);

        // Frame of spikes 1,0,1,0 held, then drained; then single-cycle latency.
        for (int k = 0; k < 10; k++) begin
            cycle(vecs[k].v, vecs[k].i, vecs[k].r, vecs[k].c);
            chk($sformatf("vec%0d_valid", k), 32'(bus.ev_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_count", k), 32'(fifo_count), 32'(vecs[k].exp_count));
            chk($sformatf("vec%0d_slot", k), 32'(slot), 32'(vecs[k].exp_slot));
            chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'(vecs[k].exp_ovf));
            chk($sformatf("vec%0d_drop", k), 32'(drop_cnt), 32'(vecs[k].exp_drop));
        end

        // Overfill: 10 pushes into 8 entries.
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_drop_cnt", 32'(drop_cnt), 32'd2);

        // Push and pop together while full.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("pushpop_count", 32'(fifo_count), 32'd8);
        chk("pushpop_drop_cnt", 32'(drop_cnt), 32'd2);

        // Clear coinciding with a drop.
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_drop_overflow", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);

        repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drained_count", 32'(fifo_count), 32'd0);
        chk("drained_valid", 32'(bus.ev_valid), 32'd0);

        // Reset with events queued.
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("queued_valid", 32'(bus.ev_valid), 32'd1);
        chk("queued_count", 32'(fifo_count), 32'd5);
        do_reset(1'b1);

        // Drop counter saturation.
        repeat (308) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_drop_cnt0", 32'(drop_cnt), 32'd0);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Three frames with a spike on the last slot.
        do_reset(1'b0);
        repeat (3) begin
            repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("frames_count", 32'(fifo_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
`ifdef SPIKE_TIMESTAMP_EN
            exp_ev = {8'(k), 2'd3};
`else
            exp_ev = 2'd3;
`endif
            chk($sformatf("frame%0d_ev_data", k), 32'(bus.ev_data), 32'(exp_ev));
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
        end

`ifdef SPIKE_TIMESTAMP_EN
        // 256 empty frames bring the timestep back to 0.
        do_reset(1'b0);
        repeat (256 * N_NEURONS) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        exp_ev = {8'd0, 2'd0};
        chk("ts_wrap_ev_data", 32'(bus.ev_data), 32'(exp_ev));
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
